// File: rtl/router_fifo.sv
// router_fifo: per-destination output FIFO of the 1x3 router, with header-driven packet length tracking.
// Optional ROUTER_FIFO_TRISTATE_EN: data_out floats on soft_reset and at packet end instead of driving 0.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0]   mem_q [DEPTH];
  logic [5:0]       count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             oe_q, oe_d;
  logic             wr, rd;
  logic [WIDTH:0]   rd_word;
  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr      = write_enb && !full;
  assign rd      = read_enb && !empty;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
  // oe_q drops once the packet has ended so the idle bus can float or read as zero
  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    count_d  = (rd && rd_word[WIDTH]) ? 6'(rd_word[WIDTH-1:2]) + 6'd1 :
               (rd && count_q != 6'd0) ? count_q - 6'd1 : count_q;
    dout_d   = rd ? rd_word[WIDTH-1:0] : (count_q == 6'd0) ? '0 : dout_q;
    oe_d     = rd ? 1'b1 : (count_q == 6'd0) ? 1'b0 : oe_q;
  end
  always_ff @(posedge clk) begin
    if (resetn || soft_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
      count_q  <= '0;
      dout_q   <= '0;
      oe_q     <= resetn;
    end else begin
      if (wr) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
    end
  end
`ifdef ROUTER_FIFO_TRISTATE_EN
  assign data_out = oe_q ? dout_q : 'z;
`else
  assign data_out = oe_q ? dout_q : '0;
`endif
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: scoreboard bench; reads push expected bytes, a monitor pops them one cycle later.
module tb_router_fifo;
  logic       clk = 0, resetn = 1, soft_reset = 0, write_enb = 0, read_enb = 0, lfd_state = 0;
  logic [7:0] data_in = '0;
  logic       full, empty;
  wire  [7:0] data_out;
  int n_chk = 0, n_pass = 0;
  logic [7:0] exp_q [$];
  logic       rd_pend = 0;
`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif
  localparam logic [7:0] PAY [8] = '{8'h3C, 8'hA5, 8'h01, 8'hFF, 8'h7E, 8'h80, 8'h5A, 8'hC3};
  localparam logic [7:0] PAR = 8'h96;

  router_fifo dut (
    .clk(clk), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
    .full(full), .empty(empty), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  always @(posedge clk) rd_pend <= read_enb;
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: got read data %h with no expected entry", data_out);
      end else check("sb_read", data_out, exp_q.pop_front());
    end
  end

  task automatic wr(input logic [7:0] d, input logic l);
    write_enb = 1; data_in = d; lfd_state = l;
    @(negedge clk);
    write_enb = 0; lfd_state = 0;
  endtask

  task automatic rd(input logic [7:0] e);
    read_enb = 1; exp_q.push_back(e);
    @(negedge clk);
    read_enb = 0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    resetn = 0;
    check("rst_empty", {7'b0, empty}, 8'd1);
    check("rst_full", {7'b0, full}, 8'd0);
    check("rst_data", data_out, 8'h00);
    // packet: header 0x21 -> 8 payload bytes + parity
    wr(8'h21, 1);
    for (int i = 0; i < 8; i++) wr(PAY[i], 0);
    wr(PAR, 0);
    check("pkt_not_empty", {7'b0, empty}, 8'd0);
    rd(8'h21);
    for (int i = 0; i < 4; i++) rd(PAY[i]);
    @(negedge clk);
    check("pkt_gap_hold", data_out, PAY[3]);
    for (int i = 4; i < 8; i++) rd(PAY[i]);
    rd(PAR);
    check("pkt_empty", {7'b0, empty}, 8'd1);
    rd(IDLE);
    // full, dropped write, simultaneous read/write while full
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 0);
    check("full_set", {7'b0, full}, 8'd1);
    check("full_not_empty", {7'b0, empty}, 8'd0);
    wr(8'hEE, 0);
    check("full_drop", {7'b0, full}, 8'd1);
    write_enb = 1; data_in = 8'hDD;
    rd(8'h40);
    write_enb = 0;
    check("simul_full_clr", {7'b0, full}, 8'd0);
    for (int i = 1; i < 16; i++) rd(8'h40 + 8'(i));
    check("drain_empty", {7'b0, empty}, 8'd1);
    rd(IDLE);
    // soft reset mid-fill, then a fresh short packet (header 0x05 -> 1 payload + parity)
    for (int i = 0; i < 5; i++) wr(8'h90 + 8'(i), 0);
    soft_reset = 1;
    @(negedge clk);
    soft_reset = 0;
    check("soft_empty", {7'b0, empty}, 8'd1);
    check("soft_full", {7'b0, full}, 8'd0);
    check("soft_data", data_out, IDLE);
    rd(IDLE);
    wr(8'h05, 1);
    wr(8'hAA, 0);
    wr(8'h55, 0);
    rd(8'h05);
    rd(8'hAA);
    rd(8'h55);
    check("pkt2_empty", {7'b0, empty}, 8'd1);
    rd(IDLE);
    @(negedge clk);
    check("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
